// File: rtl/mdc_r2_stage.sv
// Radix-2 MDC FFT stage: butterfly, optional twiddle multiply on the lower lane,
// and a delay-commutator that regroups outputs at span DEPTH for the next stage.
module mdc_r2_stage #(
  parameter int DW    = 9,
  parameter int DEPTH = 8,
  parameter int TW_W  = 9,
  parameter int SCALE = 0,
  parameter int TW_EN = 1,
  localparam int CW   = (DEPTH < 2) ? 1 : $clog2(2 * DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_up_re,
  input  logic [DW-1:0]   in_up_im,
  input  logic [DW-1:0]   in_lo_re,
  input  logic [DW-1:0]   in_lo_im,
  output logic [CW-1:0]   tw_idx,
  input  logic [TW_W-1:0] tw_re,
  input  logic [TW_W-1:0] tw_im,
  output logic            out_valid,
  output logic [DW-1:0]   out_up_re,
  output logic [DW-1:0]   out_up_im,
  output logic [DW-1:0]   out_lo_re,
  output logic [DW-1:0]   out_lo_im,
  output logic            ovf
);

  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam int PW = DW + TW_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 3);

  function automatic logic [DW:0] bfly(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic sub);
    logic [DW:0] ax, bx;
    ax = {a[DW-1], a};
    bx = {b[DW-1], b};
    return sub ? ax - bx : ax + bx;
  endfunction

  function automatic logic [DW-1:0] fit(input logic [DW:0] x);
    if (SCALE != 0) return x[DW:1];
    else if (x[DW] != x[DW-1]) return x[DW] ? MINV : MAXV;
    else return x[DW-1:0];
  endfunction

  function automatic logic p1_sat(input logic [DW:0] x);
    return (SCALE == 0) && (x[DW] != x[DW-1]);
  endfunction

  function automatic logic p2_sat(input logic [PW-1:0] x);
    return x[PW-1:DW-1] != {(PW-DW+1){x[PW-1]}};
  endfunction

  function automatic logic [DW-1:0] clip(input logic [PW-1:0] x);
    if (p2_sat(x)) return x[PW-1] ? MINV : MAXV;
    else return x[DW-1:0];
  endfunction

  // Stage P1: butterfly
  logic [DW:0]   bs_re, bs_im, bd_re, bd_im;
  logic          p1_ovf;
  logic          v1_q;
  logic [DW-1:0] s_re_q, s_im_q, d_re_q, d_im_q;

  assign bs_re  = bfly(in_up_re, in_lo_re, 1'b0);
  assign bs_im  = bfly(in_up_im, in_lo_im, 1'b0);
  assign bd_re  = bfly(in_up_re, in_lo_re, 1'b1);
  assign bd_im  = bfly(in_up_im, in_lo_im, 1'b1);
  assign p1_ovf = in_valid & (p1_sat(bs_re) | p1_sat(bs_im) | p1_sat(bd_re) | p1_sat(bd_im));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      s_re_q <= '0;
      s_im_q <= '0;
      d_re_q <= '0;
      d_im_q <= '0;
    end else if (clr) begin
      v1_q   <= 1'b0;
      s_re_q <= '0;
      s_im_q <= '0;
      d_re_q <= '0;
      d_im_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        s_re_q <= fit(bs_re);
        s_im_q <= fit(bs_im);
        d_re_q <= fit(bd_re);
        d_im_q <= fit(bd_im);
      end
    end
  end

  // Twiddle address: index of the current P1 result within the 2*DEPTH block
  logic [CW-1:0] tw_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_cnt_q <= '0;
    end else if (clr) begin
      tw_cnt_q <= '0;
    end else if (v1_q && (TW_EN != 0) && (DEPTH != 0)) begin
      tw_cnt_q <= tw_cnt_q + CW'(1);
    end
  end

  assign tw_idx = tw_cnt_q;

  // Stage P2: complex multiply of the difference, round half up, saturate
  logic signed [PW-1:0] dre_x, dim_x, twr_x, twi_x, pr_re, pr_im, rn_re, rn_im;
  logic [DW-1:0]        ml_re_d, ml_im_d;
  logic                 p2_ovf;

  assign dre_x = PW'($signed(d_re_q));
  assign dim_x = PW'($signed(d_im_q));
  assign twr_x = PW'($signed(tw_re));
  assign twi_x = PW'($signed(tw_im));
  assign pr_re = dre_x * twr_x - dim_x * twi_x;
  assign pr_im = dre_x * twi_x + dim_x * twr_x;
  assign rn_re = (pr_re + RND) >>> (TW_W - 2);
  assign rn_im = (pr_im + RND) >>> (TW_W - 2);

  always_comb begin
    ml_re_d = d_re_q;
    ml_im_d = d_im_q;
    p2_ovf  = 1'b0;
    if (TW_EN != 0) begin
      ml_re_d = clip(rn_re);
      ml_im_d = clip(rn_im);
      p2_ovf  = v1_q & (p2_sat(rn_re) | p2_sat(rn_im));
    end
  end

  logic          v2_q;
  logic [DW-1:0] mu_re_q, mu_im_q, ml_re_q, ml_im_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      mu_re_q <= '0;
      mu_im_q <= '0;
      ml_re_q <= '0;
      ml_im_q <= '0;
    end else if (clr) begin
      v2_q    <= 1'b0;
      mu_re_q <= '0;
      mu_im_q <= '0;
      ml_re_q <= '0;
      ml_im_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        mu_re_q <= s_re_q;
        mu_im_q <= s_im_q;
        ml_re_q <= ml_re_d;
        ml_im_q <= ml_im_d;
      end
    end
  end

  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (clr) ovf_q <= 1'b0;
    else ovf_q <= ovf_q | p1_ovf | p2_ovf;
  end

  // Output stage: direct register for the final stage, delay-commutator otherwise
  logic          ov_q;
  logic [DW-1:0] ou_re_q, ou_im_q, ol_re_q, ol_im_q;

  if (DEPTH == 0) begin : g_direct
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
        ov_q    <= 1'b0;
        ou_re_q <= '0;
        ou_im_q <= '0;
        ol_re_q <= '0;
        ol_im_q <= '0;
      end else begin
        ov_q <= v2_q;
        if (v2_q) begin
          ou_re_q <= mu_re_q;
          ou_im_q <= mu_im_q;
          ol_re_q <= ml_re_q;
          ol_im_q <= ml_im_q;
        end
      end
    end
  end else begin : g_comm
    logic [CW-1:0] j_q, fill_q;
    logic [DW-1:0] lre_q [DEPTH];
    logic [DW-1:0] lim_q [DEPTH];
    logic [DW-1:0] tre_q [DEPTH];
    logic [DW-1:0] tim_q [DEPTH];
    logic          sw;
    logic [DW-1:0] top_re, top_im, bot_re, bot_im;

    // MSB of the advance index flips the lane routing every DEPTH advances
    assign sw = j_q[CW-1];

    always_comb begin
      top_re = sw ? lre_q[DEPTH-1] : mu_re_q;
      top_im = sw ? lim_q[DEPTH-1] : mu_im_q;
      bot_re = sw ? mu_re_q : lre_q[DEPTH-1];
      bot_im = sw ? mu_im_q : lim_q[DEPTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
        ov_q    <= 1'b0;
        j_q     <= '0;
        fill_q  <= '0;
        ou_re_q <= '0;
        ou_im_q <= '0;
        ol_re_q <= '0;
        ol_im_q <= '0;
      end else begin
        ov_q <= v2_q && (fill_q == CW'(DEPTH));
        if (v2_q) begin
          j_q <= j_q + CW'(1);
          if (fill_q != CW'(DEPTH)) fill_q <= fill_q + CW'(1);
          ou_re_q <= tre_q[DEPTH-1];
          ou_im_q <= tim_q[DEPTH-1];
          ol_re_q <= bot_re;
          ol_im_q <= bot_im;
        end
      end
    end

    // Delay lines are not cleared by clr; out_valid masks stale contents
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          lre_q[i] <= '0;
          lim_q[i] <= '0;
          tre_q[i] <= '0;
          tim_q[i] <= '0;
        end
      end else if (v2_q && !clr) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          lre_q[i] <= lre_q[i-1];
          lim_q[i] <= lim_q[i-1];
          tre_q[i] <= tre_q[i-1];
          tim_q[i] <= tim_q[i-1];
        end
        lre_q[0] <= ml_re_q;
        lim_q[0] <= ml_im_q;
        tre_q[0] <= top_re;
        tim_q[0] <= top_im;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_up_re = ou_re_q;
  assign out_up_im = ou_im_q;
  assign out_lo_re = ol_re_q;
  assign out_lo_im = ol_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mdc_r2_stage.sv
// Bench for mdc_r2_stage: five parameterisations share one input stream; a behavioural
// model of butterfly, twiddle multiply and span-D output ordering checks streamed results.
module tb_mdc_r2_stage;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] up_re = '0, up_im = '0, lo_re = '0, lo_im = '0;
  logic signed [DW-1:0] o_ur [5];
  logic signed [DW-1:0] o_ui [5];
  logic signed [DW-1:0] o_lr [5];
  logic signed [DW-1:0] o_li [5];
  logic ov [5];
  logic of [5];
  logic t0_idx, t1_idx, t4_idx;
  logic [2:0] t2_idx;
  logic [1:0] t3_idx;
  logic signed [8:0] tw2_re, tw2_im;
  logic signed [8:0] twf_re = '0, twf_im = '0;
  int rom_re [8];
  int rom_im [8];
  int st_ur [64];
  int st_ui [64];
  int st_lr [64];
  int st_li [64];
  int tests = 0;
  int fails = 0;
  bit mdl_ovf;

  always #5 clk = ~clk;

  assign tw2_re = 9'(rom_re[t2_idx]);
  assign tw2_im = 9'(rom_im[t2_idx]);

  mdc_r2_stage #(.DW(9), .DEPTH(0), .TW_W(9), .SCALE(0), .TW_EN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .tw_idx(t0_idx), .tw_re(9'sd0), .tw_im(9'sd0), .out_valid(ov[0]),
    .out_up_re(o_ur[0]), .out_up_im(o_ui[0]), .out_lo_re(o_lr[0]), .out_lo_im(o_li[0]),
    .ovf(of[0]));

  mdc_r2_stage #(.DW(9), .DEPTH(0), .TW_W(9), .SCALE(1), .TW_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .tw_idx(t1_idx), .tw_re(9'sd0), .tw_im(9'sd0), .out_valid(ov[1]),
    .out_up_re(o_ur[1]), .out_up_im(o_ui[1]), .out_lo_re(o_lr[1]), .out_lo_im(o_li[1]),
    .ovf(of[1]));

  mdc_r2_stage #(.DW(9), .DEPTH(4), .TW_W(9), .SCALE(0), .TW_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .tw_idx(t2_idx), .tw_re(tw2_re), .tw_im(tw2_im), .out_valid(ov[2]),
    .out_up_re(o_ur[2]), .out_up_im(o_ui[2]), .out_lo_re(o_lr[2]), .out_lo_im(o_li[2]),
    .ovf(of[2]));

  mdc_r2_stage #(.DW(9), .DEPTH(2), .TW_W(9), .SCALE(0), .TW_EN(0)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .tw_idx(t3_idx), .tw_re(9'sd0), .tw_im(9'sd0), .out_valid(ov[3]),
    .out_up_re(o_ur[3]), .out_up_im(o_ui[3]), .out_lo_re(o_lr[3]), .out_lo_im(o_li[3]),
    .ovf(of[3]));

  mdc_r2_stage #(.DW(9), .DEPTH(0), .TW_W(9), .SCALE(0), .TW_EN(1)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .tw_idx(t4_idx), .tw_re(twf_re), .tw_im(twf_im), .out_valid(ov[4]),
    .out_up_re(o_ur[4]), .out_up_im(o_ui[4]), .out_lo_re(o_lr[4]), .out_lo_im(o_li[4]),
    .ovf(of[4]));

  function automatic int sat9(input int x);
    if (x > 255) begin
      mdl_ovf = 1'b1;
      return 255;
    end
    if (x < -256) begin
      mdl_ovf = 1'b1;
      return -256;
    end
    return x;
  endfunction

  function automatic logic [35:0] pk(input int a, input int b, input int c, input int d);
    return {9'(a), 9'(b), 9'(c), 9'(d)};
  endfunction

  task automatic do_clr();
    clr = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // One input pair in cycle 0; returns just after the cycle-3 edge
  task automatic send_one(input int ur, input int ui, input int lr, input int li);
    up_re = 9'(ur);
    up_im = 9'(ui);
    lo_re = 9'(lr);
    lo_im = 9'(li);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: random gaps
  task automatic run_stream(input int inst, input int n, input int mode);
    int dep, cyc, k, drain, first;
    bit twen;
    int a_re [64];
    int a_im [64];
    int b_re [64];
    int b_im [64];
    logic [35:0] expq [$];
    logic [35:0] capq [$];
    bit exp_ovf;
    logic v;
    dep = (inst == 2) ? 4 : 2;
    twen = (inst == 2);
    do_clr();
    mdl_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      int dre, dim, wr, wi;
      st_ur[i] = int'($urandom_range(0, 511)) - 256;
      st_ui[i] = int'($urandom_range(0, 511)) - 256;
      st_lr[i] = int'($urandom_range(0, 511)) - 256;
      st_li[i] = int'($urandom_range(0, 511)) - 256;
      a_re[i] = sat9(st_ur[i] + st_lr[i]);
      a_im[i] = sat9(st_ui[i] + st_li[i]);
      dre = sat9(st_ur[i] - st_lr[i]);
      dim = sat9(st_ui[i] - st_li[i]);
      if (twen) begin
        wr = rom_re[i % (2 * dep)];
        wi = rom_im[i % (2 * dep)];
        b_re[i] = sat9((dre * wr - dim * wi + 64) >>> 7);
        b_im[i] = sat9((dre * wi + dim * wr + 64) >>> 7);
      end else begin
        b_re[i] = dre;
        b_im[i] = dim;
      end
    end
    exp_ovf = mdl_ovf;
    for (int t = 0; t < n - dep; t++) begin
      int base, r;
      base = (t / (2 * dep)) * 2 * dep;
      r = t % (2 * dep);
      if (r < dep)
        expq.push_back(pk(a_re[base+r], a_im[base+r], a_re[base+dep+r], a_im[base+dep+r]));
      else
        expq.push_back(pk(b_re[base+r-dep], b_im[base+r-dep], b_re[base+r], b_im[base+r]));
    end
    cyc = 0;
    k = 0;
    drain = 0;
    first = -1;
    while (drain < 2 * dep + 8 && cyc < 20 * n + 100) begin
      if (ov[inst]) begin
        if (first < 0) first = cyc;
        capq.push_back({o_ur[inst], o_ui[inst], o_lr[inst], o_li[inst]});
      end
      if (k < n) begin
        if (mode == 0) v = 1'b1;
        else if (mode == 1) v = (cyc % 2 == 0);
        else v = 1'($urandom_range(0, 1));
      end else begin
        v = 1'b0;
        drain++;
      end
      in_valid = v;
      if (v) begin
        up_re = 9'(st_ur[k]);
        up_im = 9'(st_ui[k]);
        lo_re = 9'(st_lr[k]);
        lo_im = 9'(st_li[k]);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (capq.size() != expq.size()) begin
      fails++;
      $display("FAIL stream_count inst%0d mode%0d: got %0d pairs, want %0d",
               inst, mode, capq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < capq.size(); i++) begin
      tests++;
      if (capq[i] !== expq[i]) begin
        fails++;
        $display("FAIL stream_pair inst%0d mode%0d #%0d: got %h want %h",
                 inst, mode, i, capq[i], expq[i]);
      end
    end
    if (mode == 0) begin
      tests++;
      if (first != dep + 3) begin
        fails++;
        $display("FAIL first_valid_cycle inst%0d: got %0d want %0d", inst, first, dep + 3);
      end
    end
    tests++;
    if (of[inst] !== exp_ovf) begin
      fails++;
      $display("FAIL stream_ovf inst%0d: got %b want %b", inst, of[inst], exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({ov[i], of[i], o_ur[i], o_ui[i], o_lr[i], o_li[i]} !== 38'd0) begin
        fails++;
        $display("FAIL reset inst%0d: got %h want 0", i,
                 {ov[i], of[i], o_ur[i], o_ui[i], o_lr[i], o_li[i]});
      end
    end
    tests++;
    if (t2_idx !== 3'd0) begin
      fails++;
      $display("FAIL reset_tw_idx: got %0d want 0", t2_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    do_clr();
    send_one(100, 0, 30, 0);
    tests++;
    if (ov[0] !== 1'b1) begin
      fails++;
      $display("FAIL bypass_valid: got %b want 1", ov[0]);
    end
    tests++;
    if (o_ur[0] !== 9'sd130 || o_lr[0] !== 9'sd70 || of[0] !== 1'b0) begin
      fails++;
      $display("FAIL bypass_data: got up=%0d lo=%0d ovf=%b want 130 70 0",
               o_ur[0], o_lr[0], of[0]);
    end
    @(negedge clk);
    tests++;
    if (ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL bypass_valid_pulse: got %b want 0", ov[0]);
    end
  endtask

  task automatic test_saturate();
    do_clr();
    send_one(200, 0, -100, 0);
    tests++;
    if (o_ur[0] !== 9'sd100 || o_lr[0] !== 9'sd255 || of[0] !== 1'b1) begin
      fails++;
      $display("FAIL saturate: got up=%0d lo=%0d ovf=%b want 100 255 1",
               o_ur[0], o_lr[0], of[0]);
    end
    do_clr();
    tests++;
    if (of[0] !== 1'b0 || ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL clr_ovf: got ovf=%b valid=%b want 0 0", of[0], ov[0]);
    end
  endtask

  task automatic test_scale();
    do_clr();
    send_one(200, 0, 100, 0);
    tests++;
    if (o_ur[1] !== 9'sd150 || o_lr[1] !== 9'sd50) begin
      fails++;
      $display("FAIL scale_pos: got up=%0d lo=%0d want 150 50", o_ur[1], o_lr[1]);
    end
    send_one(-3, 0, 0, 0);
    tests++;
    if (o_ur[1] !== 9'(-2) || o_lr[1] !== 9'(-2) || of[1] !== 1'b0) begin
      fails++;
      $display("FAIL scale_floor: got up=%0d lo=%0d ovf=%b want -2 -2 0",
               o_ur[1], o_lr[1], of[1]);
    end
  endtask

  task automatic test_twiddle();
    do_clr();
    twf_re = 9'sd0;
    twf_im = 9'(-128);
    send_one(100, 0, 0, 0);
    tests++;
    if (o_lr[4] !== 9'sd0 || o_li[4] !== 9'(-100) || o_ur[4] !== 9'sd100) begin
      fails++;
      $display("FAIL twiddle_mj: got up=%0d lo=(%0d,%0d) want 100 (0,-100)",
               o_ur[4], o_lr[4], o_li[4]);
    end
    twf_re = 9'sd128;
    twf_im = 9'sd0;
    send_one(100, 0, 0, 0);
    tests++;
    if (o_lr[4] !== 9'sd100 || o_li[4] !== 9'sd0 || of[4] !== 1'b0) begin
      fails++;
      $display("FAIL twiddle_one: got lo=(%0d,%0d) ovf=%b want (100,0) 0",
               o_lr[4], o_li[4], of[4]);
    end
    do_clr();
    up_re = '0;
    up_im = '0;
    lo_re = '0;
    lo_im = '0;
    in_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      tests++;
      if (t2_idx !== 3'((n - 1) % 8)) begin
        fails++;
        $display("FAIL tw_idx step%0d: got %0d want %0d", n, t2_idx, (n - 1) % 8);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_clr();
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      up_re = 9'($urandom_range(0, 511));
      lo_re = 9'($urandom_range(0, 511));
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (ov[3] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: got %b want 1", ov[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ov[3], of[3], o_ur[3], o_ui[3], o_lr[3], o_li[3]} !== 38'd0) begin
      fails++;
      $display("FAIL async_reset: got %h want 0",
               {ov[3], of[3], o_ur[3], o_ui[3], o_lr[3], o_li[3]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(3, 16, 0);
  endtask

  task automatic test_random_twiddle();
    for (int i = 0; i < 8; i++) begin
      rom_re[i] = int'($urandom_range(0, 256)) - 128;
      rom_im[i] = int'($urandom_range(0, 256)) - 128;
    end
    run_stream(2, 32, 0);
    run_stream(2, 30, 2);
    run_stream(3, 22, 2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rom_re[i] = 0;
      rom_im[i] = 0;
    end
    test_reset();
    test_bypass();
    test_saturate();
    test_scale();
    test_twiddle();
    run_stream(3, 16, 0);
    run_stream(3, 16, 1);
    test_async_reset();
    test_random_twiddle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
